// File: rtl/dso_spi_regctl.sv
`timescale 1ns/1ps
// SPI-slave (mode 0) register access controller: turns MCU byte transactions
// into single-cycle accesses on the 8x8-bit control register bank.
module dso_spi_regctl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [2:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_s, cs_s;
  logic                   sck_prev, cs_prev, armed;
  logic                   sck_r, sck_f, cs_fall, cs_rise, mosi_q;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_sr, tx_sr, rx_byte;
  logic                   ai, byte_done;

  // cs_n chain resets low so a CS already held low at release never looks like a fresh fall
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sck_prev <= 1'b0;
      cs_prev  <= 1'b0;
      armed    <= 1'b0;
      mosi_q   <= 1'b0;
      sck_r    <= 1'b0;
      sck_f    <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
    end else begin
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
      mosi_q   <= mosi_sync[SYNC_STAGES-1];
      if (cs_s)
        armed <= 1'b1;
      sck_r    <= sck_s & ~sck_prev & ~cs_s;
      sck_f    <= ~sck_s & sck_prev & ~cs_s;
      cs_fall  <= ~cs_s & cs_prev;
      cs_rise  <= cs_s & ~cs_prev;
    end
  end

  assign byte_done = sck_r && (bit_cnt == 3'd7) && (state_q != IDLE);
  assign rx_byte   = {rx_sr[6:0], mosi_q};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = CMD;
      CMD:     if (byte_done) state_d = rx_byte[7] ? RDATA : WDATA;
      default: state_d = state_q;
    endcase
    if (cs_rise)
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bit_cnt   <= 3'd0;
      rx_sr     <= 8'h00;
      reg_addr  <= 3'd0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      ai        <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (state_q == IDLE || cs_rise) begin
        bit_cnt <= 3'd0;
        rx_sr   <= 8'h00;
      end else if (sck_r) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sr   <= rx_byte;
      end
      // address advances after the write strobe, even if CS has already risen
      if (reg_we && ai)
        reg_addr <= reg_addr + 3'd1;
      if (byte_done) begin
        case (state_q)
          CMD: begin
            reg_addr <= rx_byte[2:0];
            ai       <= rx_byte[6];
            reg_re   <= rx_byte[7];
          end
          WDATA: begin
            reg_wdata <= rx_byte;
            reg_we    <= 1'b1;
          end
          RDATA: begin
            if (ai)
              reg_addr <= reg_addr + 3'd1;
            reg_re <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // the sck fall ending a byte (count back at 0) must not shift, or the freshly loaded MSB is lost
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      tx_sr <= 8'h00;
    else if (state_q != RDATA || cs_rise)
      tx_sr <= 8'h00;
    else if (reg_re)
      tx_sr <= reg_rdata;
    else if (sck_f && bit_cnt != 3'd0)
      tx_sr <= {tx_sr[6:0], 1'b0};
  end

  assign spi_miso    = tx_sr[7];
  assign spi_miso_oe = ~cs_s & armed;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dso_spi_regctl.sv
`timescale 1ns/1ps
// Self-checking bench for dso_spi_regctl: a mode-0 SPI master plus a modelled
// register bank, with table vectors, corner-case sequences and random traffic.
module tb_dso_spi_regctl;

  localparam int HALF = 8;
  localparam int NV   = 6;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, reg_we, reg_re, busy;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic [7:0] bank [8];

  assign reg_rdata = bank[reg_addr];

  dso_spi_regctl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .nrst(nrst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      cmd;
    int              nbytes;
    logic [0:2][7:0] data;
    int              nwe;
    logic [0:2][2:0] we_addr;
    logic [0:2][7:0] we_data;
    int              nre;
    logic [0:2][7:0] miso;
    logic [2:0]      addr;
  } vec_t;

  vec_t        vecs [NV];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [10:0] we_q [$];
  logic [2:0]  re_q [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clkWait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // plays the register bank: records strobes and applies writes
  task automatic monitor();
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reg_we || reg_re)
        checkOutput("strobe_exclusive", 32'((reg_we && reg_re) || prev), 32'd0);
      if (reg_we) begin
        we_q.push_back({reg_addr, reg_wdata});
        bank[reg_addr] = reg_wdata;
      end
      if (reg_re)
        re_q.push_back(reg_addr);
      prev = reg_we || reg_re;
    end
  endtask

  task automatic bankInit();
    for (int i = 0; i < 8; i++)
      bank[i] = 8'h80 | 8'(i);
  endtask

  task automatic spiByte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      clkWait(HALF);
      rx[7-i] = spi_miso;
      spi_sck = 1'b1;
      clkWait(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input int n, input logic [0:2][7:0] d,
                               output logic [7:0] cmd_miso, output logic [0:2][7:0] miso);
    logic [7:0] b;
    we_q.delete();
    re_q.delete();
    miso = '0;
    spi_cs_n = 1'b0;
    clkWait(4);
    spiByte(cmd, 8, cmd_miso);
    for (int i = 0; i < n; i++) begin
      spiByte(d[i], 8, b);
      miso[i] = b;
    end
    clkWait(4);
    spi_cs_n = 1'b1;
    clkWait(8);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_addr"}, 32'(reg_addr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
    checkOutput({tag, "_we"}, 32'(reg_we), 32'd0);
    checkOutput({tag, "_re"}, 32'(reg_re), 32'd0);
    checkOutput({tag, "_miso"}, 32'(spi_miso), 32'd0);
    checkOutput({tag, "_oe"}, 32'(spi_miso_oe), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]      cm, b;
    logic [0:2][7:0] mi, d;
    logic [7:0]      mdl [8];
    logic [10:0]     exp_we [$];
    logic [0:2][7:0] exp_miso;
    logic [7:0]      cmd;
    logic [2:0]      a;
    int              n;

    bankInit();
    fork monitor(); join_none

    vecs[0] = '{8'h03, 1, {8'h5A, 8'h00, 8'h00}, 1, {3'd3, 3'd0, 3'd0}, {8'h5A, 8'h00, 8'h00},
                0, {8'h00, 8'h00, 8'h00}, 3'd3};
    vecs[1] = '{8'h46, 3, {8'h11, 8'h22, 8'h33}, 3, {3'd6, 3'd7, 3'd0}, {8'h11, 8'h22, 8'h33},
                0, {8'h00, 8'h00, 8'h00}, 3'd1};
    vecs[2] = '{8'hC2, 2, {8'hA5, 8'h3C, 8'h00}, 0, {3'd0, 3'd0, 3'd0}, {8'h00, 8'h00, 8'h00},
                3, {8'h82, 8'h83, 8'h00}, 3'd4};
    vecs[3] = '{8'h85, 2, {8'hFF, 8'h00, 8'h00}, 0, {3'd0, 3'd0, 3'd0}, {8'h00, 8'h00, 8'h00},
                3, {8'h85, 8'h85, 8'h00}, 3'd5};
    vecs[4] = '{8'h3A, 2, {8'hAA, 8'hBB, 8'h00}, 2, {3'd2, 3'd2, 3'd0}, {8'hAA, 8'hBB, 8'h00},
                0, {8'h00, 8'h00, 8'h00}, 3'd2};
    vecs[5] = '{8'hC7, 2, {8'h00, 8'h00, 8'h00}, 0, {3'd0, 3'd0, 3'd0}, {8'h00, 8'h00, 8'h00},
                3, {8'h87, 8'h80, 8'h00}, 3'd1};

    clkWait(5);
    checkResetOutputs("reset");
    nrst = 1'b1;
    clkWait(5);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < NV; v++) begin
      bankInit();
      applyStimulus(vecs[v].cmd, vecs[v].nbytes, vecs[v].data, cm, mi);
      checkOutput($sformatf("v%0d_cmd_miso", v), 32'(cm), 32'd0);
      for (int i = 0; i < vecs[v].nbytes; i++)
        checkOutput($sformatf("v%0d_miso%0d", v, i), 32'(mi[i]), 32'(vecs[v].miso[i]));
      checkOutput($sformatf("v%0d_we_count", v), 32'(we_q.size()), 32'(vecs[v].nwe));
      for (int i = 0; i < vecs[v].nwe && i < we_q.size(); i++)
        checkOutput($sformatf("v%0d_we%0d", v, i), 32'(we_q[i]),
                    32'({vecs[v].we_addr[i], vecs[v].we_data[i]}));
      checkOutput($sformatf("v%0d_re_count", v), 32'(re_q.size()), 32'(vecs[v].nre));
      checkOutput($sformatf("v%0d_final_addr", v), 32'(reg_addr), 32'(vecs[v].addr));
      checkOutput($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
    end

    // abort: data byte cut after 5 bits, then a clean write
    bankInit();
    we_q.delete();
    re_q.delete();
    spi_cs_n = 1'b0;
    clkWait(4);
    spiByte(8'h01, 8, b);
    spiByte(8'hFF, 5, b);
    clkWait(4);
    spi_cs_n = 1'b1;
    clkWait(8);
    checkOutput("abort_we_count", 32'(we_q.size()), 32'd0);
    checkOutput("abort_re_count", 32'(re_q.size()), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_addr", 32'(reg_addr), 32'd1);
    applyStimulus(8'h01, 1, {8'h0F, 8'h00, 8'h00}, cm, mi);
    checkOutput("post_abort_we_count", 32'(we_q.size()), 32'd1);
    if (we_q.size() > 0)
      checkOutput("post_abort_we", 32'(we_q[0]), 32'({3'd1, 8'h0F}));

    // reset in the middle of a write data byte, CS held low through release
    we_q.delete();
    re_q.delete();
    spi_cs_n = 1'b0;
    clkWait(4);
    spiByte(8'h04, 8, b);
    spiByte(8'hC3, 4, b);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    checkResetOutputs("midreset");
    clkWait(3);
    nrst = 1'b1;
    spiByte(8'h55, 8, b);
    clkWait(4);
    checkOutput("midreset_busy_cs_low", 32'(busy), 32'd0);
    spi_cs_n = 1'b1;
    clkWait(8);
    checkOutput("midreset_we_count", 32'(we_q.size()), 32'd0);
    checkOutput("midreset_re_count", 32'(re_q.size()), 32'd0);
    applyStimulus(8'h06, 1, {8'h77, 8'h00, 8'h00}, cm, mi);
    checkOutput("post_reset_we_count", 32'(we_q.size()), 32'd1);
    if (we_q.size() > 0)
      checkOutput("post_reset_we", 32'(we_q[0]), 32'({3'd6, 8'h77}));

    // random transactions against a bank-level model
    bankInit();
    for (int i = 0; i < 8; i++)
      mdl[i] = 8'h80 + 8'(i);
    for (int t = 0; t < 40; t++) begin
      cmd = 8'($urandom);
      n   = $urandom_range(1, 3);
      for (int i = 0; i < 3; i++)
        d[i] = 8'($urandom);
      exp_we.delete();
      exp_miso = '0;
      a = cmd[2:0];
      for (int i = 0; i < n; i++) begin
        if (cmd[7]) begin
          exp_miso[i] = mdl[a];
        end else begin
          exp_we.push_back({a, d[i]});
          mdl[a] = d[i];
        end
        if (cmd[6])
          a = a + 3'd1;
      end
      applyStimulus(cmd, n, d, cm, mi);
      checkOutput($sformatf("r%0d_cmd_miso", t), 32'(cm), 32'd0);
      for (int i = 0; i < n; i++)
        checkOutput($sformatf("r%0d_miso%0d", t, i), 32'(mi[i]), 32'(exp_miso[i]));
      checkOutput($sformatf("r%0d_we_count", t), 32'(we_q.size()), 32'(exp_we.size()));
      for (int i = 0; i < exp_we.size() && i < we_q.size(); i++)
        checkOutput($sformatf("r%0d_we%0d", t, i), 32'(we_q[i]), 32'(exp_we[i]));
      checkOutput($sformatf("r%0d_re_count", t), 32'(re_q.size()), cmd[7] ? 32'(n + 1) : 32'd0);
      checkOutput($sformatf("r%0d_final_addr", t), 32'(reg_addr), 32'(a));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
